ts_packet_arbiter: RTL and testbench

TS_PACKET_ARBITER -- requirements
Module: ts_packet_arbiter

---
 rtl/ts_packet_arbiter.sv | 158 +++++++++++++++
 tb/tb_ts_packet_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_packet_arbiter.sv
// Round-robin arbiter forwarding whole PKT_LEN-byte TS packets from NUM_CH FIFOs to one stream.
// One read in flight, output register plus one-entry skid; sync_err flags a bad sync byte.
module ts_packet_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 188
) (
  input  logic                         rclk,
  input  logic                         rrst_n,
  input  logic                         enable,
  input  logic [NUM_CH-1:0]            ch_pkt_avail,
  input  logic [NUM_CH-1:0]            ch_empty,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_rdata,
  output logic [NUM_CH-1:0]            ch_ren,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [$clog2(NUM_CH)-1:0]    out_ch,
  output logic                         sync_err
);
  localparam int CW = $clog2(NUM_CH);
  localparam int NW = $clog2(PKT_LEN);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t                state;
  logic [CW-1:0]         grant;
  logic [CW-1:0]         rr_ptr;
  logic [CW-1:0]         nxt;
  logic [CW-1:0]         idx;
  logic                  found;
  logic [NW-1:0]         cnt;
  logic                  rd_pend;
  logic                  rd_sop;
  logic                  rd_eop;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_vld;
  logic                  skid_sop;
  logic                  skid_eop;
  logic                  ren_any;
  logic                  cons;
  logic                  stall_in;

  always_comb begin
    found = 1'b0;
    nxt   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = CW'((int'(rr_ptr) + i) % NUM_CH);
      if (!found && ch_pkt_avail[idx]) begin
        found = 1'b1;
        nxt   = idx;
      end
    end
  end

  // A byte returning into a stalled full output would take the skid, so hold off reading then too.
  always_comb begin
    rd_data  = ch_rdata[grant*DATA_WIDTH +: DATA_WIDTH];
    cons     = out_valid && out_ready;
    stall_in = rd_pend && out_valid && !out_ready;
    ch_ren   = '0;
    if (state == XFER && !ch_empty[grant] && !skid_vld && !stall_in)
      ch_ren[grant] = 1'b1;
    ren_any  = |ch_ren;
    sync_err = rd_pend && rd_sop && (rd_data != DATA_WIDTH'(8'h47));
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
      rd_pend   <= 1'b0;
      rd_sop    <= 1'b0;
      rd_eop    <= 1'b0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
      skid_sop  <= 1'b0;
      skid_eop  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_ch    <= '0;
    end else begin
      rd_pend <= ren_any;
      rd_sop  <= ren_any && (cnt == '0);
      rd_eop  <= ren_any && (cnt == NW'(PKT_LEN - 1));

      if (cons) begin
        if (skid_vld) begin
          out_data <= skid_data;
          out_sop  <= skid_sop;
          out_eop  <= skid_eop;
          out_ch   <= grant;
          skid_vld <= rd_pend;
          if (rd_pend) begin
            skid_data <= rd_data;
            skid_sop  <= rd_sop;
            skid_eop  <= rd_eop;
          end
        end else if (rd_pend) begin
          out_data <= rd_data;
          out_sop  <= rd_sop;
          out_eop  <= rd_eop;
          out_ch   <= grant;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (rd_pend) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_data  <= rd_data;
          out_sop   <= rd_sop;
          out_eop   <= rd_eop;
          out_ch    <= grant;
        end else begin
          skid_vld  <= 1'b1;
          skid_data <= rd_data;
          skid_sop  <= rd_sop;
          skid_eop  <= rd_eop;
        end
      end

      case (state)
        IDLE: begin
          if (enable && found) begin
            grant <= nxt;
            cnt   <= '0;
            state <= XFER;
          end
        end
        XFER: begin
          if (ren_any) begin
            if (cnt == NW'(PKT_LEN - 1)) begin
              cnt   <= '0;
              state <= DRAIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (cons && out_eop) begin
            state  <= IDLE;
            rr_ptr <= (grant == CW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ts_packet_arbiter.sv
// Directed bench for ts_packet_arbiter: queue-modelled channel FIFOs, byte capture, per-scenario checks.
module tb_ts_packet_arbiter;
  localparam int NCH = 4;
  localparam int PL  = 188;

  logic            rclk = 1'b0;
  logic            rrst_n;
  logic            enable;
  logic [NCH-1:0]  ch_pkt_avail;
  logic [NCH-1:0]  ch_empty;
  logic [NCH*8-1:0] ch_rdata;
  logic [NCH-1:0]  ch_ren;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_sop;
  logic            out_eop;
  logic [1:0]      out_ch;
  logic            sync_err;

  ts_packet_arbiter #(.NUM_CH(NCH), .DATA_WIDTH(8), .PKT_LEN(PL)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .enable(enable), .ch_pkt_avail(ch_pkt_avail),
    .ch_empty(ch_empty), .ch_rdata(ch_rdata), .ch_ren(ch_ren), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .out_ch(out_ch), .sync_err(sync_err)
  );

  always #5 rclk = ~rclk;

  typedef struct { logic [7:0] d; logic sop; logic eop; logic [1:0] ch; } rx_t;

  logic [7:0]     fq [NCH][$];
  logic [7:0]     rdata [NCH];
  logic [NCH-1:0] empty_q = '1;
  logic [NCH-1:0] avail_q = '0;
  logic [NCH-1:0] stall_mask = '0;
  rx_t            rx [$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, ren_total = 0, ren_multi = 0, first_ren = 0, last_ren = 0;
  int sync_cnt = 0, unstable = 0;
  int ren_cnt [NCH];
  logic       prev_stall = 1'b0, prev_sop, prev_eop;
  logic [7:0] prev_d;
  logic [1:0] prev_ch;

  assign ch_rdata     = {rdata[3], rdata[2], rdata[1], rdata[0]};
  assign ch_empty     = empty_q | stall_mask;
  assign ch_pkt_avail = avail_q;

  // Channel FIFO model: registered read data and status flags.
  always @(posedge rclk) begin
    for (int k = 0; k < NCH; k++) begin
      if (ch_ren[k] && fq[k].size() > 0) rdata[k] <= fq[k].pop_front();
      empty_q[k] <= (fq[k].size() == 0);
      avail_q[k] <= (fq[k].size() >= PL);
    end
  end

  always @(negedge rclk) begin
    cyc++;
    if (rrst_n) begin
      if (out_valid && out_ready) rx.push_back('{out_data, out_sop, out_eop, out_ch});
      if (sync_err) sync_cnt++;
      if (ch_ren != '0) begin
        if (ren_total == 0) first_ren = cyc;
        last_ren = cyc;
        ren_total++;
        if ($countones(ch_ren) > 1) ren_multi++;
        for (int k = 0; k < NCH; k++) if (ch_ren[k]) ren_cnt[k]++;
      end
      if (prev_stall && (!out_valid || out_data !== prev_d || out_sop !== prev_sop ||
                         out_eop !== prev_eop || out_ch !== prev_ch)) unstable++;
      prev_stall = out_valid && !out_ready;
      prev_d = out_data; prev_sop = out_sop; prev_eop = out_eop; prev_ch = out_ch;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic [7:0] exp_byte(logic [7:0] first, int seed, int i);
    return (i == 0) ? first : 8'((i + seed) & 255);
  endfunction

  function automatic int pkt_errs(int base, int ch, logic [7:0] first, int seed);
    int e;
    rx_t r;
    e = 0;
    for (int i = 0; i < PL; i++) begin
      if (base + i >= rx.size()) begin e++; continue; end
      r = rx[base + i];
      if (r.d !== exp_byte(first, seed, i)) e++;
      if (r.sop !== (i == 0)) e++;
      if (r.eop !== (i == PL - 1)) e++;
      if (r.ch !== 2'(ch)) e++;
    end
    return e;
  endfunction

  task automatic load_pkt(input int ch, input logic [7:0] first, input int seed);
    for (int i = 0; i < PL; i++) fq[ch].push_back(exp_byte(first, seed, i));
  endtask

  task automatic clear_mon();
    rx.delete();
    ren_total = 0; ren_multi = 0; first_ren = 0; last_ren = 0; sync_cnt = 0; unstable = 0;
    for (int k = 0; k < NCH; k++) ren_cnt[k] = 0;
  endtask

  task automatic do_reset();
    rrst_n = 1'b0; out_ready = 1'b1; enable = 1'b1; stall_mask = '0;
    for (int k = 0; k < NCH; k++) fq[k].delete();
    repeat (3) @(posedge rclk);
    #1 rrst_n = 1'b1;
    clear_mon();
    repeat (2) @(posedge rclk);
    #1;
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge rclk); #1;
      if (rx.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rrst_n = 1'b0; enable = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < NCH; k++) rdata[k] = 8'h00;
    clear_mon();
    repeat (2) @(posedge rclk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", out_data); end
    n_checks++; if (out_sop !== 1'b0) begin n_fail++; $display("FAIL rst_sop: got %b want 0", out_sop); end
    n_checks++; if (out_eop !== 1'b0) begin n_fail++; $display("FAIL rst_eop: got %b want 0", out_eop); end
    n_checks++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL rst_ch: got %0d want 0", out_ch); end
    n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL rst_sync: got %b want 0", sync_err); end
    n_checks++; if (ch_ren !== 4'b0) begin n_fail++; $display("FAIL rst_ren: got %b want 0000", ch_ren); end
  endtask

  task automatic test_single();
    bit ok;
    int e;
    do_reset();
    enable = 1'b0;
    load_pkt(1, 8'h47, 0);
    repeat (20) @(posedge rclk);
    #1;
    n_checks++; if (ren_total !== 0) begin n_fail++; $display("FAIL idle_disabled_ren: got %0d reads want 0", ren_total); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_disabled_valid: got %b want 0", out_valid); end
    enable = 1'b1;
    wait_rx(PL, 600, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got %0d bytes want %0d", rx.size(), PL); end
    e = pkt_errs(0, 1, 8'h47, 0);
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL single_bytes: got %0d errors want 0", e); end
    n_checks++; if (ren_cnt[1] !== PL || ren_total !== PL) begin n_fail++; $display("FAIL single_ren_count: got %0d/%0d want %0d", ren_cnt[1], ren_total, PL); end
    n_checks++; if (last_ren - first_ren !== PL - 1) begin n_fail++; $display("FAIL single_ren_rate: got span %0d want %0d", last_ren - first_ren, PL - 1); end
    n_checks++; if (sync_cnt !== 0) begin n_fail++; $display("FAIL single_sync: got %0d pulses want 0", sync_cnt); end
    repeat (10) @(posedge rclk);
    #1;
    n_checks++; if (rx.size() !== PL) begin n_fail++; $display("FAIL single_extra: got %0d bytes want %0d", rx.size(), PL); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int e;
    int exp_ch [5];
    int exp_seed [5];
    exp_ch = '{0, 1, 2, 3, 0};
    exp_seed = '{10, 30, 40, 50, 20};
    do_reset();
    load_pkt(0, 8'h47, 10); load_pkt(0, 8'h47, 20);
    load_pkt(1, 8'h47, 30); load_pkt(2, 8'h47, 40); load_pkt(3, 8'h47, 50);
    wait_rx(5 * PL, 3000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_timeout: got %0d bytes want %0d", rx.size(), 5 * PL); end
    for (int p = 0; p < 5; p++) begin
      e = pkt_errs(p * PL, exp_ch[p], 8'h47, exp_seed[p]);
      n_checks++; if (e !== 0) begin n_fail++; $display("FAIL rr_pkt%0d: got %0d errors want 0 (ch %0d)", p, e, exp_ch[p]); end
    end
    n_checks++; if (ren_multi !== 0) begin n_fail++; $display("FAIL rr_onehot: got %0d multi-hot cycles want 0", ren_multi); end
  endtask

  task automatic test_backpressure();
    int e;
    do_reset();
    load_pkt(2, 8'h47, 60);
    for (int c = 0; c < 3000; c++) begin
      @(posedge rclk); #1;
      out_ready = (c % 3 == 0);
      if (rx.size() > 0) enable = 1'b0;
      if (rx.size() >= PL) break;
    end
    out_ready = 1'b1;
    repeat (5) @(posedge rclk);
    #1;
    enable = 1'b1;
    n_checks++; if (rx.size() !== PL) begin n_fail++; $display("FAIL bp_count: got %0d bytes want %0d", rx.size(), PL); end
    e = pkt_errs(0, 2, 8'h47, 60);
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL bp_bytes: got %0d errors want 0", e); end
    n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes while stalled want 0", unstable); end
    n_checks++; if (ren_cnt[2] !== PL) begin n_fail++; $display("FAIL bp_ren: got %0d want %0d", ren_cnt[2], PL); end
  endtask

  task automatic test_empty_stall();
    bit ok;
    int e, r0, r1;
    do_reset();
    load_pkt(3, 8'h47, 70);
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(posedge rclk); #1;
      if (ren_cnt[3] >= 60) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_start: got %0d reads want 60", ren_cnt[3]); end
    stall_mask[3] = 1'b1;
    r0 = ren_cnt[3];
    repeat (10) @(posedge rclk);
    #1;
    r1 = ren_cnt[3];
    stall_mask[3] = 1'b0;
    n_checks++; if (r1 !== r0) begin n_fail++; $display("FAIL stall_ren_held: got %0d reads while empty want 0", r1 - r0); end
    wait_rx(PL, 600, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_resume: got %0d bytes want %0d", rx.size(), PL); end
    e = pkt_errs(0, 3, 8'h47, 70);
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL stall_bytes: got %0d errors want 0", e); end
    n_checks++; if (ren_cnt[3] !== PL) begin n_fail++; $display("FAIL stall_ren_total: got %0d want %0d", ren_cnt[3], PL); end
  endtask

  task automatic test_sync_err();
    bit ok;
    int e;
    do_reset();
    load_pkt(0, 8'h48, 80);
    wait_rx(PL, 600, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sync_timeout: got %0d bytes want %0d", rx.size(), PL); end
    n_checks++; if (sync_cnt !== 1) begin n_fail++; $display("FAIL sync_pulse: got %0d cycles want 1", sync_cnt); end
    e = pkt_errs(0, 0, 8'h48, 80);
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL sync_fwd: got %0d errors want 0", e); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int e;
    do_reset();
    load_pkt(1, 8'h47, 5);
    wait_rx(PL, 600, ok);
    load_pkt(2, 8'h47, 90);
    wait_rx(PL + 90, 600, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_reach90: got %0d bytes want %0d", rx.size(), PL + 90); end
    rrst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    n_checks++; if (ch_ren !== 4'b0) begin n_fail++; $display("FAIL mid_ren: got %b want 0000", ch_ren); end
    n_checks++; if (out_data !== 8'h00 || out_ch !== 2'd0) begin n_fail++; $display("FAIL mid_data: got %h/%0d want 00/0", out_data, out_ch); end
    n_checks++; if (out_sop !== 1'b0 || out_eop !== 1'b0) begin n_fail++; $display("FAIL mid_flags: got %b%b want 00", out_sop, out_eop); end
    fq[2].delete();
    load_pkt(0, 8'h47, 100);
    load_pkt(3, 8'h47, 110);
    repeat (3) @(posedge rclk);
    #1 rrst_n = 1'b1;
    clear_mon();
    wait_rx(PL, 600, ok);
    n_checks++; if (!ok || rx[0].ch !== 2'd0) begin n_fail++; $display("FAIL mid_first_grant: got ch %0d want 0", ok ? rx[0].ch : 2'd3); end
    e = pkt_errs(0, 0, 8'h47, 100);
    n_checks++; if (e !== 0) begin n_fail++; $display("FAIL mid_pkt: got %0d errors want 0", e); end
  endtask

  initial begin
    rrst_n = 1'b0; enable = 1'b0; out_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_empty_stall();
    test_sync_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
